prog_mem: RTL and testbench
===========================

// Module: prog_mem
// PURPOSE
//  Instruction memory responder for the 4-bit CPU: returns the 8-bit instruction at the CPU's 4-bit
//  fetch address, combinationally, in the same cycle.
//  Also a byte-serial program loader: 16 instruction bytes, then 1 checksum byte.
//  cpu_hold keeps the CPU in reset until a load passes its checksum; drive cpu n_reset = ~cpu_hold & ~reset.
// PARAMETERS
//  DEPTH   16    instruction words; fixed by the 4-bit fetch address
//  ADDR_W  4     fetch address width
//  DATA_W  8     instruction width (4-bit opcode + 4-bit imm)
// PORTS
//  clk       in   1       system clock, all state on rising edge
//  reset     in   1       synchronous, active-high reset
//  addr      in   ADDR_W  CPU fetch address
//  data      out  DATA_W  instruction at addr, combinational read
//  ld_start  in   1       1-cycle pulse: begin (or restart) a program load
//  ld_valid  in   1       ld_byte is valid this cycle
//  ld_byte   in   DATA_W  load byte: 16 program bytes, then the checksum
//  ld_ready  out  1       loader accepts a byte this cycle (transfer = ld_valid & ld_ready)
//  ld_done   out  1       1-cycle pulse: load completed with a good checksum
//  ld_err    out  1       checksum mismatch; sticky until ld_start or reset
//  cpu_hold  out  1       1 = hold the CPU in reset
// BEHAVIOUR
//  Reset: all mem words=8'h00; state=EMPTY; wptr=0; sum=0; ld_ready=0, ld_done=0, ld_err=0, cpu_hold=1.
//  Read: data = mem[addr] in every state, no latency. A same-cycle write is visible from the next cycle.
//  States:
//   EMPTY  no valid program; cpu_hold=1.
//   LOAD   ld_ready=1; on transfer: mem[wptr]<=ld_byte; sum<=sum+ld_byte (mod 256); wptr++.
//          Transfer with wptr=15 -> CHECK. wptr returns to 0.
//   CHECK  ld_ready=1; next transfer is the checksum.
//          ld_byte==sum -> RUN, ld_done=1 for 1 cycle.
//          ld_byte!=sum -> ERROR, ld_err=1.
//   RUN    cpu_hold=0, ld_ready=0; ld_valid ignored.
//   ERROR  cpu_hold=1, ld_err=1, ld_ready=0; memory keeps the bytes just written.
//  ld_start in any state:
//   next cycle: state=LOAD, wptr=0, sum=0, ld_err=0, cpu_hold=1.
//   ld_start has priority: a ld_valid in the same cycle is dropped and not written.
//  Registered outputs: cpu_hold, ld_done, ld_err and ld_ready are all registered.
//   ld_done and the 1->0 fall of cpu_hold occur in the cycle after the checksum transfer.
//   cpu_hold rises in the cycle after ld_start.
//  ld_valid gaps (ld_valid=0) are allowed in LOAD/CHECK; state, wptr and sum hold.
//  Reset mid-load: memory cleared, state EMPTY; the partial load is discarded.
//  Restart mid-load: ld_start discards progress; memory keeps the old words until they are overwritten.
//  Memory is never written outside LOAD; ld_byte is don't-care when ld_valid=0.
// TESTING
//  T1 reset: pulse reset -> cpu_hold=1, ld_ready=0, ld_err=0; sweep addr 0..15 -> data=8'h00.
//  T2 good load: ld_start, bytes 8'h01..8'h10, checksum 8'h88.
//     -> 1 cycle later: ld_done=1, cpu_hold=0.
//     -> then addr=4'h5 -> data=8'h06; addr=4'hF -> data=8'h10.
//  T3 bad checksum: as T2 but checksum 8'h89 -> ld_err=1, cpu_hold=1, ld_ready=0, no ld_done.
//     -> then ld_start -> ld_err=0 next cycle.
//  T4 restart: load 7 bytes 8'hAA, ld_start, bytes 8'h10..8'h1F, checksum 8'h78
//     -> RUN; addr=4'h2 -> data=8'h12.
//  T5 gaps and priority: ld_valid toggling 1/0 during load -> same result as T2.
//     -> ld_start with ld_valid=1, ld_byte=8'hFF -> mem[0] not written.
//     -> ld_valid=1 in RUN -> memory unchanged.
//  T6 reset mid-load after 9 bytes -> EMPTY, all data=8'h00, cpu_hold=1.

Source files
------------

// File: rtl/prog_mem.sv
// Instruction memory for the 4-bit CPU with a byte-serial, checksum-verified program loader.
// The CPU fetches combinationally; cpu_hold keeps it in reset until a load passes its checksum.
module prog_mem #(
    parameter int DEPTH  = 16,
    parameter int ADDR_W = 4,
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] addr,
    output logic [DATA_W-1:0] data,
    input  logic              ld_start,
    input  logic              ld_valid,
    input  logic [DATA_W-1:0] ld_byte,
    output logic              ld_ready,
    output logic              ld_done,
    output logic              ld_err,
    output logic              cpu_hold
);

    typedef enum logic [2:0] {
        S_EMPTY,
        S_LOAD,
        S_CHECK,
        S_RUN,
        S_ERROR
    } state_t;

    state_t              state;
    logic [ADDR_W-1:0]   wptr;
    logic [DATA_W-1:0]   sum;
    logic [DATA_W-1:0]   mem [DEPTH];
    logic                xfer;

    // ld_ready is a registered copy of "state is LOAD or CHECK", so this is the handshake.
    assign xfer = ld_valid & ld_ready;

    assign data = mem[addr];

    always_ff @(posedge clk) begin
        if (reset) begin
            // NOTE: the memory is cleared by reset on purpose, so a partial load never survives it;
            // this makes it a flop array rather than a RAM macro, which is fine at 16 words.
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
            state    <= S_EMPTY;
            wptr     <= '0;
            sum      <= '0;
            ld_ready <= 1'b0;
            ld_done  <= 1'b0;
            ld_err   <= 1'b0;
            cpu_hold <= 1'b1;
        end else begin
            ld_done <= 1'b0;
            // ld_start wins over any transfer in the same cycle; that byte is dropped.
            if (ld_start) begin
                state    <= S_LOAD;
                wptr     <= '0;
                sum      <= '0;
                ld_ready <= 1'b1;
                ld_err   <= 1'b0;
                cpu_hold <= 1'b1;
            end else begin
                case (state)
                    S_LOAD: begin
                        if (xfer) begin
                            mem[wptr] <= ld_byte;
                            sum       <= sum + ld_byte;
                            wptr      <= wptr + 1'b1;
                            if (wptr == ADDR_W'(DEPTH - 1)) begin
                                state <= S_CHECK;
                            end
                        end
                    end
                    S_CHECK: begin
                        if (xfer) begin
                            ld_ready <= 1'b0;
                            if (ld_byte == sum) begin
                                state    <= S_RUN;
                                ld_done  <= 1'b1;
                                cpu_hold <= 1'b0;
                            end else begin
                                state  <= S_ERROR;
                                ld_err <= 1'b1;
                            end
                        end
                    end
                    default: begin
                        // EMPTY, RUN and ERROR only leave on ld_start or reset.
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_prog_mem.sv
// Self-checking bench for prog_mem: directed load scenarios plus randomized loads,
// compared against a byte-queue model of the loader and a word array for the memory.
module tb_prog_mem;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] addr;
    logic [7:0] data;
    logic       ld_start;
    logic       ld_valid;
    logic [7:0] ld_byte;
    logic       ld_ready;
    logic       ld_done;
    logic       ld_err;
    logic       cpu_hold;

    int total = 0;
    int bad   = 0;

    // Reference model: accepted bytes of the current load, memory image and status flags.
    logic [7:0] m_mem [16];
    logic [7:0] m_q [$];
    bit         m_loading;
    bit         m_running;
    bit         m_err;
    bit         m_done;

    prog_mem dut (
        .clk      (clk),
        .reset    (reset),
        .addr     (addr),
        .data     (data),
        .ld_start (ld_start),
        .ld_valid (ld_valid),
        .ld_byte  (ld_byte),
        .ld_ready (ld_ready),
        .ld_done  (ld_done),
        .ld_err   (ld_err),
        .cpu_hold (cpu_hold)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_step(input bit r, input bit s, input bit v, input logic [7:0] b);
        int total_sum;
        m_done = 1'b0;
        if (r) begin
            foreach (m_mem[i]) m_mem[i] = 8'h00;
            m_q.delete();
            m_loading = 1'b0;
            m_running = 1'b0;
            m_err     = 1'b0;
        end else if (s) begin
            m_q.delete();
            m_loading = 1'b1;
            m_running = 1'b0;
            m_err     = 1'b0;
        end else if (m_loading && v) begin
            if (m_q.size() < 16) begin
                m_mem[m_q.size()] = b;
                m_q.push_back(b);
            end else begin
                total_sum = 0;
                foreach (m_q[i]) total_sum += int'(m_q[i]);
                m_loading = 1'b0;
                if (int'(b) == total_sum % 256) begin
                    m_running = 1'b1;
                    m_done    = 1'b1;
                end else begin
                    m_err = 1'b1;
                end
            end
        end
    endtask

    // One clock: drive inputs at the falling edge, check registered outputs at the next one.
    task automatic cycle(input bit r, input bit s, input bit v, input logic [7:0] b);
        reset    = r;
        ld_start = s;
        ld_valid = v;
        ld_byte  = b;
        model_step(r, s, v, b);
        @(posedge clk);
        @(negedge clk);
        reset    = 1'b0;
        ld_start = 1'b0;
        ld_valid = 1'b0;
        ld_byte  = 8'($urandom);
        check("cpu_hold", 32'(cpu_hold), 32'(!m_running));
        check("ld_ready", 32'(ld_ready), 32'(m_loading));
        check("ld_err", 32'(ld_err), 32'(m_err));
        check("ld_done", 32'(ld_done), 32'(m_done));
        addr = 4'($urandom_range(0, 15));
        #1;
        check("data_rand", 32'(data), 32'(m_mem[addr]));
    endtask

    task automatic sweep(input string tag);
        for (int a = 0; a < 16; a++) begin
            addr = 4'(a);
            #1;
            check(tag, 32'(data), 32'(m_mem[a]));
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 1'b0, 8'($urandom));
    endtask

    // Sends 16 program bytes base..base+15 (mod 256), optionally with ld_valid gaps, then the checksum.
    task automatic load_seq(input logic [7:0] base, input bit gaps, input logic [7:0] csum);
        for (int i = 0; i < 16; i++) begin
            cycle(1'b0, 1'b0, 1'b1, 8'(base + 8'(i)));
            if (gaps) idle(1);
        end
        cycle(1'b0, 1'b0, 1'b1, csum);
    endtask

    initial begin
        logic [7:0] bytes [16];
        int         s;
        bit         good;
        int         cut;

        reset    = 1'b0;
        ld_start = 1'b0;
        ld_valid = 1'b0;
        ld_byte  = 8'h00;
        addr     = 4'h0;
        @(negedge clk);

        // T1: reset state
        cycle(1'b1, 1'b0, 1'b0, 8'h00);
        check("t1_hold", 32'(cpu_hold), 32'd1);
        check("t1_ready", 32'(ld_ready), 32'd0);
        check("t1_err", 32'(ld_err), 32'd0);
        sweep("t1_data");
        idle(2);

        // T2: good load 01..10, checksum 88
        cycle(1'b0, 1'b1, 1'b0, 8'h00);
        check("t2_ready", 32'(ld_ready), 32'd1);
        load_seq(8'h01, 1'b0, 8'h88);
        check("t2_done", 32'(ld_done), 32'd1);
        check("t2_hold", 32'(cpu_hold), 32'd0);
        addr = 4'h5; #1; check("t2_addr5", 32'(data), 32'h06);
        addr = 4'hF; #1; check("t2_addrF", 32'(data), 32'h10);
        idle(1);
        check("t2_done_pulse", 32'(ld_done), 32'd0);

        // T3: bad checksum, then restart clears ld_err
        cycle(1'b0, 1'b1, 1'b0, 8'h00);
        check("t3_hold_rise", 32'(cpu_hold), 32'd1);
        load_seq(8'h01, 1'b0, 8'h89);
        check("t3_err", 32'(ld_err), 32'd1);
        check("t3_hold", 32'(cpu_hold), 32'd1);
        check("t3_ready", 32'(ld_ready), 32'd0);
        check("t3_done", 32'(ld_done), 32'd0);
        idle(2);
        check("t3_err_sticky", 32'(ld_err), 32'd1);
        cycle(1'b0, 1'b1, 1'b0, 8'h00);
        check("t3_err_clear", 32'(ld_err), 32'd0);

        // T4: partial load of AA, restart, load 10..1F with checksum 78
        for (int i = 0; i < 7; i++) cycle(1'b0, 1'b0, 1'b1, 8'hAA);
        addr = 4'h2; #1; check("t4_partial", 32'(data), 32'hAA);
        cycle(1'b0, 1'b1, 1'b0, 8'h00);
        addr = 4'h2; #1; check("t4_old_kept", 32'(data), 32'hAA);
        load_seq(8'h10, 1'b0, 8'h78);
        check("t4_done", 32'(ld_done), 32'd1);
        check("t4_hold", 32'(cpu_hold), 32'd0);
        addr = 4'h2; #1; check("t4_addr2", 32'(data), 32'h12);

        // T5: gapped load, ld_valid in RUN, ld_start with ld_valid
        cycle(1'b0, 1'b1, 1'b0, 8'h00);
        load_seq(8'h01, 1'b1, 8'h88);
        check("t5_done", 32'(ld_done), 32'd1);
        check("t5_hold", 32'(cpu_hold), 32'd0);
        for (int i = 0; i < 4; i++) cycle(1'b0, 1'b0, 1'b1, 8'h55);
        check("t5_run_hold", 32'(cpu_hold), 32'd0);
        sweep("t5_run_mem");
        cycle(1'b0, 1'b1, 1'b1, 8'hFF);
        addr = 4'h0; #1; check("t5_prio_mem0", 32'(data), 32'h01);
        check("t5_prio_ready", 32'(ld_ready), 32'd1);

        // T6: reset after 9 bytes of a load
        for (int i = 0; i < 9; i++) cycle(1'b0, 1'b0, 1'b1, 8'(8'hC0 + 8'(i)));
        cycle(1'b1, 1'b0, 1'b0, 8'h00);
        check("t6_hold", 32'(cpu_hold), 32'd1);
        check("t6_ready", 32'(ld_ready), 32'd0);
        sweep("t6_data");
        for (int a = 0; a < 16; a++) begin
            addr = 4'(a);
            #1;
            check("t6_zero", 32'(data), 32'h00);
        end

        // Randomized loads: random bytes, random gaps, stray ld_valid, good or bad checksum.
        for (int it = 0; it < 12; it++) begin
            good = ($urandom_range(0, 2) != 0);
            cut  = $urandom_range(0, 3) == 0 ? int'($urandom_range(1, 15)) : 0;
            cycle(1'b0, 1'b1, 1'b0, 8'($urandom));
            if (cut != 0) begin
                for (int i = 0; i < cut; i++) cycle(1'b0, 1'b0, 1'b1, 8'($urandom));
                cycle(1'b0, 1'b1, $urandom_range(0, 1) == 1, 8'($urandom));
            end
            s = 0;
            for (int i = 0; i < 16; i++) begin
                bytes[i] = 8'($urandom);
                s += int'(bytes[i]);
            end
            for (int i = 0; i < 16; i++) begin
                if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
                cycle(1'b0, 1'b0, 1'b1, bytes[i]);
            end
            cycle(1'b0, 1'b0, 1'b1, good ? 8'(s) : 8'(s + 1));
            check("rnd_done", 32'(ld_done), 32'(good));
            check("rnd_err", 32'(ld_err), 32'(!good));
            for (int a = 0; a < 16; a++) begin
                addr = 4'(a);
                #1;
                check("rnd_mem", 32'(data), 32'(bytes[a]));
            end
            for (int i = 0; i < 3; i++) cycle(1'b0, 1'b0, $urandom_range(0, 1) == 1, 8'($urandom));
            if ($urandom_range(0, 4) == 0) cycle(1'b1, 1'b0, 1'b0, 8'h00);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
